// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: in-order instruction fetch sequencer with redirect handling and a decode buffer
module ifu_fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_exu_taken,
    input  logic [XLEN-1:0] i_exu_jaddr,
    input  logic            i_bpu_taken,
    input  logic [XLEN-1:0] i_bpu_jaddr,
    output logic            o_ibus_req,
    output logic [XLEN-1:0] o_ibus_addr,
    input  logic            i_ibus_gnt,
    input  logic            i_ibus_rvalid,
    input  logic [XLEN-1:0] i_ibus_rdata,
    output logic            o_inst_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_inst_ready,
    output logic            o_redirect
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fly_pc [DEPTH];
    logic [AW-1:0]   fly_wr, fly_rd;
    logic [CW-1:0]   outstanding, drop, count;
    logic [XLEN-1:0] buf_pc [DEPTH];
    logic [XLEN-1:0] buf_inst [DEPTH];
    logic [AW-1:0]   buf_wr, buf_rd;
    logic [XLEN-1:0] target;
    logic            grant, push, pop;

    assign o_redirect   = i_exu_taken | i_bpu_taken;
    assign target       = i_exu_taken ? i_exu_jaddr : i_bpu_jaddr;
    // issue is gated on registered occupancy, so a same-cycle pop reopens issue only next cycle
    assign o_ibus_req   = !i_rst && !o_redirect && ({1'b0, outstanding} + {1'b0, count} < FULL);
    assign o_ibus_addr  = pc;
    assign grant        = o_ibus_req & i_ibus_gnt;
    assign push         = i_ibus_rvalid & !o_redirect & (drop == '0);
    assign o_inst_valid = count != '0;
    assign pop          = o_inst_valid & i_inst_ready;
    assign o_inst       = buf_inst[buf_rd];
    assign o_inst_pc    = buf_pc[buf_rd];

    always_ff @(posedge i_clk) begin
        if (grant) fly_pc[fly_wr] <= pc;
        if (push) begin
            buf_pc[buf_wr]   <= fly_pc[fly_rd];
            buf_inst[buf_wr] <= i_ibus_rdata;
        end
    end

    // the in-flight FIFO pops on every response, stale or not, to stay aligned with the bus
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc          <= RESET_PC;
            fly_wr      <= '0;
            fly_rd      <= '0;
            outstanding <= '0;
            drop        <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
            count       <= '0;
        end else begin
            pc          <= o_redirect ? target : grant ? pc + XLEN'(4) : pc;
            fly_wr      <= fly_wr + AW'(grant);
            fly_rd      <= fly_rd + AW'(i_ibus_rvalid);
            outstanding <= outstanding + CW'(grant) - CW'(i_ibus_rvalid);
            drop        <= o_redirect ? outstanding - CW'(i_ibus_rvalid)
                                      : drop - CW'(i_ibus_rvalid && drop != '0);
            buf_wr      <= o_redirect ? '0 : buf_wr + AW'(push);
            buf_rd      <= o_redirect ? '0 : buf_rd + AW'(pop);
            count       <= o_redirect ? '0 : count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) assert (!(i_ibus_rvalid && outstanding == '0));
    end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed scoreboard bench for ifu_fetch_ctrl with a simple in-order bus responder
module tb_ifu_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 0;
    logic        rst = 1;
    logic        exu_taken = 0, bpu_taken = 0;
    logic [31:0] exu_jaddr = 0, bpu_jaddr = 0;
    logic        req, gnt;
    logic [31:0] addr;
    logic        rvalid = 0;
    logic [31:0] rdata = 0;
    logic        inst_valid, redirect;
    logic [31:0] inst, inst_pc;
    logic        ready = 1;
    logic        hold = 0;
    int          n_gnt = 0, gnt_limit = 0;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend[$];
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    ifu_fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_exu_taken(exu_taken), .i_exu_jaddr(exu_jaddr),
        .i_bpu_taken(bpu_taken), .i_bpu_jaddr(bpu_jaddr),
        .o_ibus_req(req), .o_ibus_addr(addr), .i_ibus_gnt(gnt),
        .i_ibus_rvalid(rvalid), .i_ibus_rdata(rdata),
        .o_inst_valid(inst_valid), .o_inst(inst), .o_inst_pc(inst_pc),
        .i_inst_ready(ready), .o_redirect(redirect)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // bus: grants up to gnt_limit, returns data in order one cycle after grant unless held
    assign gnt = n_gnt < gnt_limit;
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            rvalid <= 0;
            n_gnt  <= 0;
        end else begin
            if (req && gnt) begin
                pend.push_back(addr);
                n_gnt <= n_gnt + 1;
            end
            if (!hold && pend.size() > 0) begin
                rvalid <= 1;
                rdata  <= mem(pend.pop_front());
            end else rvalid <= 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && inst_valid && ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("inst_pc", inst_pc, mon_e);
                check("inst", inst, mem(mon_e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1; exu_taken = 0; bpu_taken = 0; gnt_limit = 0; hold = 0; ready = 1;
        exp_q.delete();
        settle();
        check("rst_req", req, 0);
        check("rst_valid", inst_valid, 0);
        step();
        rst = 0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 100) begin
            settle();
            i++;
        end
        repeat (4) settle();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int i;
        // sequential fetch from reset
        do_reset();
        gnt_limit = 6;
        for (int k = 0; k < 6; k++) exp_q.push_back(RST_PC + 32'(4 * k));
        settle();
        check("first_req", req, 1);
        check("first_addr", addr, RST_PC);
        drain("t1_drain");

        // decode stall fills the cap, pop reopens issue a cycle later
        do_reset();
        ready = 0; gnt_limit = 3;
        exp_q.push_back(RST_PC); exp_q.push_back(RST_PC + 4); exp_q.push_back(RST_PC + 8);
        repeat (6) step();
        settle();
        check("stall_grants", n_gnt, 2);
        check("stall_req", req, 0);
        check("stall_valid", inst_valid, 1);
        check("stall_head", inst_pc, RST_PC);
        step();
        ready = 1;
        settle();
        check("pop_cycle_req", req, 0);
        step();
        settle();
        check("reopen_req", req, 1);
        check("reopen_addr", addr, RST_PC + 8);
        drain("t2_drain");

        // execute redirect with two responses outstanding
        do_reset();
        hold = 1; gnt_limit = 2;
        exp_q.push_back(32'h8000_0100);
        repeat (4) step();
        settle();
        check("t3_out2", n_gnt, 2);
        check("t3_req_full", req, 0);
        step();
        exu_taken = 1; exu_jaddr = 32'h8000_0100;
        settle();
        check("t3_redirect", redirect, 1);
        check("t3_req_supp", req, 0);
        step();
        exu_taken = 0; hold = 0; gnt_limit = 3;
        settle();
        i = 0;
        while (!req && i < 8) begin
            check("t3_no_stale", inst_valid, 0);
            step();
            settle();
            i++;
        end
        check("t3_req_back", req, 1);
        check("t3_target", addr, 32'h8000_0100);
        drain("t3_drain");

        // exu beats bpu when both redirect together
        do_reset();
        exu_taken = 1; exu_jaddr = 32'h0000_0200; bpu_taken = 1; bpu_jaddr = 32'h0000_0300;
        settle();
        check("t4_redirect", redirect, 1);
        check("t4_req_supp", req, 0);
        step();
        exu_taken = 0; bpu_taken = 0;
        settle();
        check("t4_redirect_off", redirect, 0);
        check("t4_req", req, 1);
        check("t4_target", addr, 32'h0000_0200);
        step();
        gnt_limit = 1;
        exp_q.push_back(32'h0000_0200);
        drain("t4_drain");

        // redirect in the same cycle as the only outstanding response
        do_reset();
        hold = 1; gnt_limit = 1;
        step();
        hold = 0;
        step();
        exu_taken = 1; exu_jaddr = 32'h8000_0400;
        settle();
        check("t5_redirect", redirect, 1);
        step();
        exu_taken = 0; gnt_limit = 2;
        exp_q.push_back(32'h8000_0400);
        settle();
        check("t5_valid", inst_valid, 0);
        check("t5_req", req, 1);
        check("t5_target", addr, 32'h8000_0400);
        drain("t5_drain");

        // predictor redirect with empty buffer, then PC wrap
        do_reset();
        bpu_taken = 1; bpu_jaddr = 32'hFFFF_FFFC;
        settle();
        check("t6_redirect", redirect, 1);
        check("t6_valid", inst_valid, 0);
        step();
        bpu_taken = 0; gnt_limit = 2;
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
        settle();
        check("t6_req", req, 1);
        check("t6_addr", addr, 32'hFFFF_FFFC);
        step();
        settle();
        check("wrap_req", req, 1);
        check("wrap_addr", addr, 32'h0000_0000);
        drain("t6_drain");

        // reset with two requests in flight
        do_reset();
        hold = 1; gnt_limit = 2;
        repeat (3) step();
        settle();
        check("t7_out2", n_gnt, 2);
        check("t7_req_full", req, 0);
        do_reset();
        gnt_limit = 1;
        exp_q.push_back(RST_PC);
        settle();
        check("t7_req", req, 1);
        check("t7_addr", addr, RST_PC);
        drain("t7_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
